// File: rtl/agu_pipe.sv
// agu_pipe: two-stage address generation unit with a valid/ready handshake.
// Stage A forms (index << scale) + sext(disp); stage B adds base and flags non-canonical results.
module agu_pipe #(
   parameter int ADDR_W  = 64,
   parameter int VA_BITS = 48,
   parameter int DISP_W  = 32,
   parameter int NUM_OPS = 3,
   parameter int TAG_W   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_OPS-1:0]        in_mem_mask,
   input  logic [NUM_OPS*ADDR_W-1:0] in_base,
   input  logic [NUM_OPS*ADDR_W-1:0] in_index,
   input  logic [NUM_OPS-1:0]        in_index_valid,
   input  logic [NUM_OPS*2-1:0]      in_scale,
   input  logic [NUM_OPS*DISP_W-1:0] in_disp,
   input  logic [TAG_W-1:0]          in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_OPS*ADDR_W-1:0] out_addr,
   output logic [NUM_OPS-1:0]        out_mem_mask,
   output logic [NUM_OPS-1:0]        out_fault,
   output logic [TAG_W-1:0]          out_tag,
   output logic                      busy
);

   logic                aValid;
   logic [ADDR_W-1:0]   aPart [NUM_OPS];
   logic [ADDR_W-1:0]   aBase [NUM_OPS];
   logic [NUM_OPS-1:0]  aMask;
   logic [TAG_W-1:0]    aTag;

   logic                bValid;
   logic [ADDR_W-1:0]   bAddr [NUM_OPS];
   logic [NUM_OPS-1:0]  bFault;
   logic [NUM_OPS-1:0]  bMask;
   logic [TAG_W-1:0]    bTag;

   logic [ADDR_W-1:0]   partNext [NUM_OPS];
   logic [ADDR_W-1:0]   addrNext [NUM_OPS];
   logic [NUM_OPS-1:0]  faultNext;

   logic bDrain;
   logic aAdvance;
   logic inFire;

   // A may move forward whenever B is empty or B hands its result off this cycle.
   assign bDrain   = bValid & out_ready;
   assign aAdvance = aValid & (~bValid | out_ready);
   assign in_ready = reset & ~flush & (~aValid | aAdvance);
   assign inFire   = in_valid & in_ready;

   genvar g;
   for (g = 0; g < NUM_OPS; g++) begin : gChan
      logic [ADDR_W-1:0] idxVal;
      logic [ADDR_W-1:0] dispExt;
      logic [ADDR_W-1:0] sum;

      assign idxVal      = in_index[g*ADDR_W +: ADDR_W];
      assign dispExt     = {{(ADDR_W-DISP_W){in_disp[g*DISP_W+DISP_W-1]}}, in_disp[g*DISP_W +: DISP_W]};
      assign partNext[g] = (in_index_valid[g] ? (idxVal << in_scale[g*2 +: 2]) : '0) + dispExt;

      assign sum         = aBase[g] + aPart[g];
      assign addrNext[g] = aMask[g] ? sum : '0;

      if (VA_BITS < ADDR_W) begin : gCanon
         logic [ADDR_W-VA_BITS:0] upper;
         assign upper        = sum[ADDR_W-1:VA_BITS-1];
         assign faultNext[g] = aMask[g] & ~((&upper) | ~(|upper));
      end else begin : gNoCanon
         assign faultNext[g] = 1'b0;
      end

      assign out_addr[g*ADDR_W +: ADDR_W] = bAddr[g];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         aValid <= 1'b0;
         bValid <= 1'b0;
         aMask  <= '0;
         aTag   <= '0;
         bMask  <= '0;
         bFault <= '0;
         bTag   <= '0;
         for (int i = 0; i < NUM_OPS; i++) begin
            aBase[i] <= '0;
            aPart[i] <= '0;
            bAddr[i] <= '0;
         end
      end else if (flush) begin
         aValid <= 1'b0;
         bValid <= 1'b0;
      end else begin
         if (aAdvance) begin
            bValid <= 1'b1;
            bMask  <= aMask;
            bFault <= faultNext;
            bTag   <= aTag;
            for (int i = 0; i < NUM_OPS; i++) begin
               bAddr[i] <= addrNext[i];
            end
         end else if (bDrain) begin
            bValid <= 1'b0;
         end

         if (inFire) begin
            aValid <= 1'b1;
            aMask  <= in_mem_mask;
            aTag   <= in_tag;
            for (int i = 0; i < NUM_OPS; i++) begin
               aBase[i] <= in_base[i*ADDR_W +: ADDR_W];
               aPart[i] <= partNext[i];
            end
         end else if (aAdvance) begin
            aValid <= 1'b0;
         end
      end
   end

   assign out_valid    = bValid;
   assign out_mem_mask = bMask;
   assign out_fault    = bFault;
   assign out_tag      = bTag;
   assign busy         = aValid | bValid;

endmodule

// File: tb/tb_agu_pipe.sv
// Self-checking bench for agu_pipe: transaction-level reference model plus directed scenarios
// and a randomized phase with back-pressure, flushes and resets.
module tb_agu_pipe;
   localparam int AW = 64;
   localparam int NO = 3;
   localparam int DW = 32;
   localparam int TW = 16;
   localparam int CW = NO*AW;

   logic            clk = 1'b0;
   logic            reset;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [NO-1:0]   in_mem_mask;
   logic [NO*AW-1:0] in_base;
   logic [NO*AW-1:0] in_index;
   logic [NO-1:0]   in_index_valid;
   logic [NO*2-1:0] in_scale;
   logic [NO*DW-1:0] in_disp;
   logic [TW-1:0]   in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [NO*AW-1:0] out_addr;
   logic [NO-1:0]   out_mem_mask;
   logic [NO-1:0]   out_fault;
   logic [TW-1:0]   out_tag;
   logic            busy;

   always #5 clk = ~clk;

   agu_pipe dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_mask(in_mem_mask), .in_base(in_base), .in_index(in_index),
      .in_index_valid(in_index_valid), .in_scale(in_scale), .in_disp(in_disp),
      .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_mem_mask(out_mem_mask), .out_fault(out_fault), .out_tag(out_tag),
      .busy(busy)
   );

   typedef struct {
      logic [CW-1:0] addr;
      logic [NO-1:0] fault;
      logic [NO-1:0] mask;
      logic [TW-1:0] tag;
      int            stamp;
   } exp_t;

   int checks = 0;
   int errors = 0;
   exp_t q[$];
   logic [TW-1:0] seenTags[$];
   int hsCycles[$];
   int acceptCycles[$];
   int n = 0;
   bit started = 0;

   bit            prevStall = 0;
   logic [CW-1:0] prevAddr;
   logic [NO-1:0] prevFault;
   logic [NO-1:0] prevMask;
   logic [TW-1:0] prevTag;

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Effective address from the architectural formula; canonical means the value lies
   // in the low or high half of the implemented 48-bit space.
   function automatic exp_t predict(input logic [CW-1:0] b, input logic [CW-1:0] ix,
                                    input logic [NO-1:0] iv, input logic [NO*2-1:0] sc,
                                    input logic [NO*DW-1:0] d, input logic [NO-1:0] m,
                                    input logic [TW-1:0] t);
      exp_t e;
      logic [AW-1:0] a;
      logic [AW-1:0] mult;
      e.addr  = '0;
      e.fault = '0;
      e.mask  = m;
      e.tag   = t;
      e.stamp = 0;
      for (int c = 0; c < NO; c++) begin
         case (sc[2*c +: 2])
            2'd0:    mult = 64'd1;
            2'd1:    mult = 64'd2;
            2'd2:    mult = 64'd4;
            default: mult = 64'd8;
         endcase
         a = b[c*AW +: AW] + (iv[c] ? ix[c*AW +: AW] * mult : 64'd0) + 64'($signed(d[c*DW +: DW]));
         if (m[c]) begin
            e.addr[c*AW +: AW] = a;
            e.fault[c] = !(a < 64'h0000_8000_0000_0000 || a >= 64'hFFFF_8000_0000_0000);
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      bit expValid;
      bit expReady;
      exp_t e;
      n++;
      expValid = 0;
      if (q.size() > 0) expValid = (n >= q[0].stamp + 2);
      expReady = reset && !flush && !(q.size() >= 2 && !out_ready);
      if (started) begin
         chk("in_ready", CW'(in_ready), CW'(expReady));
         chk("out_valid", CW'(out_valid), CW'(expValid));
         chk("busy", CW'(busy), CW'(q.size() != 0));
         if (prevStall) begin
            chk("stall_addr", out_addr, prevAddr);
            chk("stall_fault", CW'(out_fault), CW'(prevFault));
            chk("stall_mask", CW'(out_mem_mask), CW'(prevMask));
            chk("stall_tag", CW'(out_tag), CW'(prevTag));
         end
         if (expValid && out_ready) begin
            e = q.pop_front();
            chk("res_addr", out_addr, e.addr);
            chk("res_fault", CW'(out_fault), CW'(e.fault));
            chk("res_mask", CW'(out_mem_mask), CW'(e.mask));
            chk("res_tag", CW'(out_tag), CW'(e.tag));
            seenTags.push_back(out_tag);
            hsCycles.push_back(n);
         end
      end
      prevStall = started && reset && !flush && out_valid && !out_ready;
      prevAddr  = out_addr;
      prevFault = out_fault;
      prevMask  = out_mem_mask;
      prevTag   = out_tag;
      if (!reset || flush) begin
         q.delete();
      end else if (in_valid && expReady) begin
         e = predict(in_base, in_index, in_index_valid, in_scale, in_disp, in_mem_mask, in_tag);
         e.stamp = n;
         q.push_back(e);
         acceptCycles.push_back(n);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid       = 1'b0;
      flush          = 1'b0;
      in_mem_mask    = '0;
      in_base        = '0;
      in_index       = '0;
      in_index_valid = '0;
      in_scale       = '0;
      in_disp        = '0;
      in_tag         = '0;
   endtask

   task automatic oneCh(input int c, input logic [AW-1:0] b, input logic [AW-1:0] ix,
                        input logic iv, input logic [1:0] sc, input logic [DW-1:0] d,
                        input logic [TW-1:0] t);
      idle();
      in_base[c*AW +: AW]  = b;
      in_index[c*AW +: AW] = ix;
      in_index_valid[c]    = iv;
      in_scale[2*c +: 2]   = sc;
      in_disp[c*DW +: DW]  = d;
      in_mem_mask[c]       = 1'b1;
      in_tag               = t;
      in_valid             = 1'b1;
   endtask

   task automatic randTxn(input logic [TW-1:0] t);
      logic [AW-1:0] b;
      for (int c = 0; c < NO; c++) begin
         case ($urandom_range(0, 3))
            0:       b = {16'h0000, 16'($urandom), $urandom};
            1:       b = {16'hFFFF, 16'($urandom), $urandom};
            2:       b = {32'h00007FFF, $urandom};
            default: b = {$urandom, $urandom};
         endcase
         in_base[c*AW +: AW]  = b;
         in_index[c*AW +: AW] = {$urandom, $urandom} >> $urandom_range(0, 63);
         in_disp[c*DW +: DW]  = $urandom;
         in_scale[2*c +: 2]   = 2'($urandom);
      end
      in_mem_mask    = 3'($urandom);
      in_index_valid = 3'($urandom);
      in_tag         = t;
   endtask

   initial begin
      exp_t e;
      int k;
      bit fired;
      int lim;

      reset = 1'b0;
      out_ready = 1'b0;
      idle();
      tick();
      started = 1;
      tick();
      reset = 1'b1;
      tick();

      // Basic address with scaled index and negative displacement on channel 2
      out_ready = 1'b1;
      oneCh(2, 64'h1000, 64'h10, 1'b1, 2'd3, 32'hFFFF_FFF8, 16'h00A1);
      e = predict(in_base, in_index, in_index_valid, in_scale, in_disp, in_mem_mask, in_tag);
      chk("model_basic", CW'(e.addr[2*AW +: AW]), CW'(64'h1078));
      tick();
      in_valid = 1'b0;
      tick();
      chk("basic_valid", CW'(out_valid), CW'(1'b1));
      chk("basic_addr2", CW'(out_addr[2*AW +: AW]), CW'(64'h1078));
      chk("basic_addr01", CW'(out_addr[2*AW-1:0]), CW'(128'h0));
      chk("basic_fault", CW'(out_fault), CW'(3'b000));

      // Canonical-boundary crossing, then full wrap-around
      oneCh(0, 64'h0000_7FFF_FFFF_FFF0, 64'h0, 1'b0, 2'd0, 32'h20, 16'h00B1);
      e = predict(in_base, in_index, in_index_valid, in_scale, in_disp, in_mem_mask, in_tag);
      chk("model_noncanon", CW'({e.fault[0], e.addr[AW-1:0]}), CW'({1'b1, 64'h0000_8000_0000_0010}));
      tick();
      oneCh(0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 1'b0, 2'd0, 32'h20, 16'h00B2);
      e = predict(in_base, in_index, in_index_valid, in_scale, in_disp, in_mem_mask, in_tag);
      chk("model_wrap", CW'({e.fault[0], e.addr[AW-1:0]}), CW'({1'b0, 64'h10}));
      tick();
      in_valid = 1'b0;
      chk("noncanon_addr", CW'(out_addr[AW-1:0]), CW'(64'h0000_8000_0000_0010));
      chk("noncanon_fault", CW'(out_fault), CW'(3'b001));
      tick();
      chk("wrap_addr", CW'(out_addr[AW-1:0]), CW'(64'h10));
      chk("wrap_fault", CW'(out_fault), CW'(3'b000));
      tick();
      tick();

      // Back-pressure stream, tags 1..6
      seenTags.delete();
      k = 1;
      for (int cyc = 0; cyc < 60 && (k <= 6 || q.size() > 0); cyc++) begin
         out_ready = (cyc % 3 == 0);
         in_valid  = (k <= 6);
         randTxn(16'(k));
         @(negedge clk);
         fired = in_valid && in_ready;
         tick();
         if (fired) k++;
      end
      idle();
      out_ready = 1'b1;
      repeat (3) tick();
      chk("bp_drained", CW'(q.size()), CW'(0));
      chk("bp_count", CW'(seenTags.size()), CW'(6));
      for (int i = 0; i < seenTags.size() && i < 6; i++)
         chk("bp_tag_order", CW'(seenTags[i]), CW'(i + 1));

      // Throughput: ten back-to-back accepts and results
      hsCycles.delete();
      acceptCycles.delete();
      for (int i = 0; i < 10; i++) begin
         randTxn(16'(16'h0100 + i));
         in_valid = 1'b1;
         tick();
      end
      idle();
      repeat (4) tick();
      chk("tp_accepts", CW'(acceptCycles.size()), CW'(10));
      chk("tp_results", CW'(hsCycles.size()), CW'(10));
      if (acceptCycles.size() > 0) begin
         for (int i = 0; i < hsCycles.size() && i < 10; i++)
            chk("tp_result_cycle", CW'(hsCycles[i]), CW'(acceptCycles[0] + 2 + i));
      end

      // Flush with both stages full and a new input offered
      out_ready = 1'b0;
      randTxn(16'd7);
      in_valid = 1'b1;
      tick();
      randTxn(16'd8);
      tick();
      chk("fl_full_busy", CW'(busy), CW'(1'b1));
      randTxn(16'd9);
      flush = 1'b1;
      tick();
      idle();
      chk("fl_busy", CW'(busy), CW'(1'b0));
      chk("fl_out_valid", CW'(out_valid), CW'(1'b0));
      seenTags.delete();
      out_ready = 1'b1;
      repeat (4) tick();
      chk("fl_nothing_out", CW'(seenTags.size()), CW'(0));

      // Reset mid-stream
      out_ready = 1'b0;
      randTxn(16'd10);
      in_valid = 1'b1;
      tick();
      randTxn(16'd11);
      tick();
      idle();
      reset = 1'b0;
      tick();
      chk("rst_out_valid", CW'(out_valid), CW'(1'b0));
      chk("rst_busy", CW'(busy), CW'(1'b0));
      chk("rst_addr", out_addr, CW'(0));
      chk("rst_side", CW'({out_fault, out_mem_mask, out_tag}), CW'(0));
      reset = 1'b1;
      #1;
      chk("rst_in_ready", CW'(in_ready), CW'(1'b1));
      out_ready = 1'b1;
      oneCh(1, 64'h2000, 64'h3, 1'b1, 2'd1, 32'h10, 16'h0066);
      tick();
      in_valid = 1'b0;
      tick();
      chk("rst_new_valid", CW'(out_valid), CW'(1'b1));
      chk("rst_new_addr", CW'(out_addr[AW +: AW]), CW'(64'h2016));
      chk("rst_new_tag", CW'(out_tag), CW'(16'h0066));
      tick();

      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         randTxn(16'($urandom));
         in_valid  = ($urandom_range(0, 99) < 70);
         out_ready = ($urandom_range(0, 99) < 60);
         flush     = ($urandom_range(0, 99) < 3);
         reset     = !($urandom_range(0, 199) == 0);
         tick();
      end
      idle();
      reset = 1'b1;
      out_ready = 1'b1;
      lim = 0;
      while (q.size() > 0 && lim < 10) begin
         tick();
         lim++;
      end
      tick();
      chk("rand_drained", CW'(q.size()), CW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
